// File: rtl/lga_pkg.sv
// Shared FHP lattice-gas definitions: cell type, bit positions, chirality modes, lane collision rule.
// Latency: none; package only.
// Backpressure: n/a.
package lga_pkg;

    typedef logic [7:0] cell_t;

    localparam int OBST_BIT = 7;
    localparam int REST_BIT = 6;

    // Chirality source selection for lcol_pipe
    localparam int CHIR_PORT = 0;   // per-lane bit taken from in_chir
    localparam int CHIR_LFSR = 1;   // lane i uses LFSR bit i
    localparam int CHIR_ALT  = 2;   // all lanes share a bit that flips per beat

    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    // Collision of one cell. Obstacles bounce every mover to the opposite
    // direction (rotate the 6-bit ring by 3) and keep the rest particle.
    function automatic cell_t lga_collide(input cell_t c, input logic chir);
        cell_t      res;
        logic [6:0] s;
        logic [6:0] n;
        s = c[6:0];
        n = s;
        case (s)
            7'd96:  n = 7'd17;
            7'd17:  n = 7'd96;
            7'd80:  n = 7'd40;
            7'd40:  n = 7'd80;
            7'd72:  n = 7'd20;
            7'd20:  n = 7'd72;
            7'd68:  n = 7'd10;
            7'd10:  n = 7'd68;
            7'd66:  n = 7'd5;
            7'd5:   n = 7'd66;
            7'd65:  n = 7'd34;
            7'd34:  n = 7'd65;
            7'd21:  n = 7'd42;
            7'd42:  n = 7'd21;
            7'd85:  n = 7'd106;
            7'd106: n = 7'd85;
            // Head-on pairs rotate one way or the other depending on chirality
            7'd18:  n = chir ? 7'd36  : 7'd9;
            7'd36:  n = chir ? 7'd9   : 7'd18;
            7'd9:   n = chir ? 7'd18  : 7'd36;
            7'd100: n = chir ? 7'd73  : 7'd82;
            7'd73:  n = chir ? 7'd82  : 7'd100;
            7'd82:  n = chir ? 7'd100 : 7'd73;
            default: n = s;
        endcase
        if (c[OBST_BIT]) begin
            res = {1'b1, c[REST_BIT], c[2:0], c[5:3]};
        end else begin
            res = {1'b0, n};
        end
        return res;
    endfunction

    function automatic logic [2:0] popcnt7(input logic [6:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lga_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) supplying per-lane chirality bits.
// Latency: new state visible the cycle after step/load.
// Backpressure: none; steps only when told. Load beats step; a zero seed becomes 16'hACE1.
// Ports: clk, rst_n; i_step advance one state; i_load/i_seed reload; o_bits low OUT_W state bits.
module lga_lfsr
    import lga_pkg::*;
#(
    parameter logic [15:0] SEED  = LFSR_DEFAULT,
    parameter int          OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_step,
    input  logic             i_load,
    input  logic [15:0]      i_seed,
    output logic [OUT_W-1:0] o_bits
);

    // An all-zero LFSR locks up, so a zero seed is never allowed in
    localparam logic [15:0] RST_SEED = (SEED == 16'h0000) ? LFSR_DEFAULT : SEED;

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_SEED;
        end else if (i_load) begin
            r_state <= (i_seed == 16'h0000) ? LFSR_DEFAULT : i_seed;
        end else if (i_step) begin
            r_state <= {w_fb, r_state[15:1]};
        end
    end

    assign o_bits = r_state[OUT_W-1:0];

endmodule

// File: rtl/lcol_pipe.sv
// Multi-lane FHP lattice-gas collision engine, LANES cells per beat, optional conservation checker.
// Latency: 2 cycles (S1 capture, S2 lookup result), 1 beat/cycle throughput.
// Backpressure: single advance enable; stalls hold both stages, in_ready = !out_valid | out_ready.
// Ports: clk/rst_n; in_valid/in_ready/in_cells/in_chir input beat; seed_load/seed_val LFSR reload;
//        out_valid/out_ready/out_cells output beat; err_o sticky conservation error.
// Build option: define LCOL_CONSERVE_CHECK_EN to include the particle/obstacle conservation checker.
module lcol_pipe
    import lga_pkg::*;
#(
    parameter int          LANES     = 4,
    parameter int          CHIR_MODE = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_cells,
    input  logic [LANES-1:0]   in_chir,
    input  logic               seed_load,
    input  logic [15:0]        seed_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_cells,
    output logic               err_o
);

    logic               w_adv;
    logic               w_accept;
    logic [LANES-1:0]   w_lfsr_bits;
    logic [LANES-1:0]   w_chir;
    logic [8*LANES-1:0] w_coll;

    logic               r_s1_vld;
    logic [8*LANES-1:0] r_s1_cells;
    logic [LANES-1:0]   r_s1_chir;
    logic               r_out_vld;
    logic [8*LANES-1:0] r_out_cells;
    logic               r_alt;

    assign w_adv    = !r_out_vld || out_ready;
    assign w_accept = in_valid && w_adv;
    assign in_ready = w_adv;

    lga_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (LANES)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_step (w_accept),
        .i_load (seed_load),
        .i_seed (seed_val),
        .o_bits (w_lfsr_bits)
    );

    // Chirality is resolved when the beat is accepted, so the LFSR/alt-bit
    // value that goes with a beat is the one current at its acceptance.
    always_comb begin
        w_chir = in_chir;
        case (CHIR_MODE)
            CHIR_LFSR: w_chir = w_lfsr_bits;
            CHIR_ALT:  w_chir = {LANES{r_alt}};
            default:   w_chir = in_chir;
        endcase
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_coll[8*g +: 8] = lga_collide(r_s1_cells[8*g +: 8], r_s1_chir[g]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_cells  <= '0;
            r_s1_chir   <= '0;
            r_out_vld   <= 1'b0;
            r_out_cells <= '0;
            r_alt       <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld  <= in_valid;
            r_out_vld <= r_s1_vld;
            r_alt     <= r_alt ^ in_valid;
            if (in_valid) begin
                r_s1_cells <= in_cells;
                r_s1_chir  <= w_chir;
            end
            // Bubbles leave the last data in place; only out_valid moves
            if (r_s1_vld) begin
                r_out_cells <= w_coll;
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_cells = r_out_cells;

`ifdef LCOL_CONSERVE_CHECK_EN
    logic [LANES-1:0] w_lane_bad;
    logic             r_err;

    for (genvar g = 0; g < LANES; g++) begin : g_chk
        assign w_lane_bad[g] =
            (popcnt7(r_s1_cells[8*g +: 7]) != popcnt7(w_coll[8*g +: 7])) ||
            (r_s1_cells[8*g+OBST_BIT] != w_coll[8*g+OBST_BIT]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_adv && r_s1_vld && (|w_lane_bad)) begin
            r_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && w_adv && r_s1_vld) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_lane_bad[i]) begin
                    $error("lcol_pipe: conservation violated on lane %0d", i);
                end
            end
        end
    end
`endif

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lcol_pipe.sv
// Bench for lcol_pipe: port-chirality instance (a) for directed vectors and stalls,
// LFSR-chirality instance (b) for seed handling and a long randomized stream.
// Both share clock and reset.
module tb_lcol_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_in_valid = 1'b0, a_in_ready, a_seed_load = 1'b0;
    logic [31:0] a_in_cells = '0, a_out_cells;
    logic [3:0]  a_in_chir = '0;
    logic [15:0] a_seed_val = '0;
    logic        a_out_valid, a_out_ready = 1'b1, a_err;

    logic        b_in_valid = 1'b0, b_in_ready, b_seed_load = 1'b0;
    logic [31:0] b_in_cells = '0, b_out_cells;
    logic [3:0]  b_in_chir = '0;
    logic [15:0] b_seed_val = '0;
    logic        b_out_valid, b_out_ready = 1'b1, b_err;
    logic        b_rand_rdy = 1'b0;

    int          n_err = 0;
    int          n_chk = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [15:0] m_lfsr;
    logic        a_stalled = 1'b0, b_stalled = 1'b0;
    logic [31:0] a_hold_cells, b_hold_cells;
    int          a_stall_cnt = 0;
    logic [31:0] t_c, bc;
    logic [3:0]  t_ch;

    always #5 clk = ~clk;

    lcol_pipe #(.LANES(4), .CHIR_MODE(0), .LFSR_SEED(16'hACE1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_cells(a_in_cells), .in_chir(a_in_chir),
        .seed_load(a_seed_load), .seed_val(a_seed_val),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_cells(a_out_cells), .err_o(a_err)
    );

    lcol_pipe #(.LANES(4), .CHIR_MODE(1), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_cells(b_in_cells), .in_chir(b_in_chir),
        .seed_load(b_seed_load), .seed_val(b_seed_val),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_cells(b_out_cells), .err_o(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference lane model: head-on movers rotate by one position (direction by
    // chirality), the symmetric triple flips, and the listed pairs swap.
    localparam logic [6:0] PA [6] = '{7'd96, 7'd80, 7'd72, 7'd68, 7'd66, 7'd65};
    localparam logic [6:0] PB [6] = '{7'd17, 7'd40, 7'd20, 7'd10, 7'd5,  7'd34};

    function automatic logic [7:0] ref_lane(input logic [7:0] c, input logic ch);
        logic [7:0] r;
        logic [5:0] m;
        m = c[5:0];
        r = c;
        if (c[7]) begin
            r = {1'b1, c[6], c[2:0], c[5:3]};
        end else if (m == 6'd9 || m == 6'd18 || m == 6'd36) begin
            r = {1'b0, c[6], ch ? {m[4:0], m[5]} : {m[0], m[5:1]}};
        end else if (m == 6'd21 || m == 6'd42) begin
            r = {1'b0, c[6], ~m};
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (c[6:0] == PA[k]) r = {1'b0, PB[k]};
                if (c[6:0] == PB[k]) r = {1'b0, PA[k]};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_beat(input logic [31:0] c, input logic [3:0] ch);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = ref_lane(c[8*l +: 8], ch[l]);
        return r;
    endfunction

    function automatic logic [7:0] pick_cell();
        logic [7:0] v;
        v = 8'($urandom);
        if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 5))
                0: v = 8'd18;
                1: v = 8'd36;
                2: v = 8'd9;
                3: v = 8'd100;
                4: v = 8'd73;
                default: v = 8'd82;
            endcase
        end
        return v;
    endfunction

    task automatic send_a(input logic [31:0] cells, input logic [3:0] ch, input logic [31:0] exp);
        logic ok;
        ok = 1'b0;
        a_in_valid = 1'b1;
        a_in_cells = cells;
        a_in_chir  = ch;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = a_in_ready;
        end
        if (ok) qa.push_back(exp);
        else chk("a_accept_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] cells);
        logic ok;
        logic fb;
        ok = 1'b0;
        b_in_valid = 1'b1;
        b_in_cells = cells;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = b_in_ready;
        end
        if (ok) begin
            qb.push_back(ref_beat(cells, m_lfsr[3:0]));
            fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
            m_lfsr = {fb, m_lfsr[15:1]};
        end else begin
            chk("b_accept_timeout", {31'd0, ok}, 32'd1);
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        b_out_ready = b_rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            a_stalled = 1'b0;
        end else begin
            if (a_stalled) begin
                chk("a_hold_vld", {31'd0, a_out_valid}, 32'd1);
                chk("a_hold_dat", a_out_cells, a_hold_cells);
            end
            a_stalled = 1'b0;
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) chk("a_unexpected_beat", 32'(qa.size()), 32'd1);
                else chk("a_out", a_out_cells, qa.pop_front());
            end else if (a_out_valid) begin
                chk("a_in_rdy_stall", {31'd0, a_in_ready}, 32'd0);
                a_stalled    = 1'b1;
                a_hold_cells = a_out_cells;
                a_stall_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_stalled = 1'b0;
        end else begin
            if (b_stalled) chk("b_hold_dat", b_out_cells, b_hold_cells);
            b_stalled = 1'b0;
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) chk("b_unexpected_beat", 32'(qb.size()), 32'd1);
                else chk("b_out", b_out_cells, qb.pop_front());
            end else if (b_out_valid) begin
                b_stalled    = 1'b1;
                b_hold_cells = b_out_cells;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (5) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_cells", a_out_cells, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);
        chk("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Chirality with latency check on an empty pipe
        send_a(32'h09241212, 4'b0101, 32'h24090924);
        chk("lat_1cyc_vld", {31'd0, a_out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_2cyc_vld", {31'd0, a_out_valid}, 32'd1);
        chk("lat_2cyc_dat", a_out_cells, 32'h24090924);

        // Obstacles, pass-through and swaps, chiral triples with rest particle
        send_a(32'h87C10355, 4'b0000, 32'hB8C8036A);
        send_a(32'h6A7F6011, 4'b0000, 32'h557F1160);
        send_a(32'h64495212, 4'b1111, 32'h49526424);
        send_a(32'h64495209, 4'b0000, 32'h52644924);
        send_a(32'h50284814, 4'b1010, 32'h28501448);

        // Random stream with a mid-stream stall
        a_stall_cnt = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    t_c  = $urandom;
                    t_ch = 4'($urandom);
                    send_a(t_c, t_ch, ref_beat(t_c, t_ch));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 a_out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 100 && qa.size() != 0; t++) @(posedge clk);
        #1;
        chk("a_drain", 32'(qa.size()), 32'd0);
        chk("a_stall_seen", {31'd0, (a_stall_cnt >= 2)}, 32'd1);

        // LFSR seeding, then long stream on the LFSR-chirality instance
        b_seed_load = 1'b1;
        b_seed_val  = 16'h1234;
        @(posedge clk);
        #1;
        chk("lfsr_load", {16'd0, dut_b.u_lfsr.r_state}, 32'h1234);
        b_seed_val = 16'h0000;
        @(posedge clk);
        #1;
        b_seed_load = 1'b0;
        chk("lfsr_zero_seed", {16'd0, dut_b.u_lfsr.r_state}, 32'hACE1);
        m_lfsr     = 16'hACE1;
        b_rand_rdy = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            for (int l = 0; l < 4; l++) bc[8*l +: 8] = pick_cell();
            send_b(bc);
        end
        b_rand_rdy = 1'b0;
        for (int t = 0; t < 100 && qb.size() != 0; t++) @(posedge clk);
        #1;
        chk("b_drain", 32'(qb.size()), 32'd0);
        chk("b_err", {31'd0, b_err}, 32'd0);
        chk("a_err", {31'd0, a_err}, 32'd0);

        // Reset asserted mid-stream while output is stalled
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_cells  = 32'h12121212;
        a_in_chir   = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_vld", {31'd0, a_out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("midrst_out_cells", a_out_cells, 32'd0);
        chk("midrst_lfsr", {16'd0, dut_b.u_lfsr.r_state}, 32'hACE1);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", {31'd0, a_out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
